mips_load_store_unit: RTL and testbench

- Sits between the MIPS datapath MEM stage and the word-wide, big-endian, byte-addressed data memory.
- Converts LB/LBU/LH/LHU/LW/SB/SH/SW requests into aligned word accesses.
- Sub-word stores are done as read-modify-write; loads are sign- or zero-extended.
- Flags misaligned and out-of-range accesses and signals completion with a one-cycle done pulse.

---
 rtl/mips_load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_mips_load_store_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mips_load_store_unit.sv
// mips_load_store_unit
//   Bridges the MIPS MEM stage to a word-wide, big-endian, byte-addressed
//   data memory. Loads (LB/LBU/LH/LHU/LW) read one aligned word and extract
//   and extend the addressed lane. SW writes directly. SB/SH read the word,
//   merge the new lane, and write it back. Misaligned, illegal-size and
//   out-of-range requests finish with addr_err and raise no memory strobe.
//
// Ports:
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   req                request, sampled only in IDLE
//   op_store           1 = store, 0 = load
//   op_size            00 byte, 01 half, 10 word, 11 illegal
//   op_unsigned        zero-extend loads
//   addr, wdata        byte address, store data (low bits for byte/half)
//   busy, done         not-IDLE flag, one-cycle completion pulse
//   addr_err           rejected access, valid with done
//   rdata              registered load result
//   mem_address        word-aligned memory address
//   write_data         word driven to the memory
//   sig_mem_read/write memory strobes
//   read_data          memory word, combinational with mem_address
module mips_load_store_unit #(
    parameter int MEM_BYTES  = 1024,
    parameter bit ADDR_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        op_store,
    input  logic [1:0]  op_size,
    input  logic        op_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        addr_err,
    output logic [31:0] rdata,
    output logic [31:0] mem_address,
    output logic [31:0] write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] read_data
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_store;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_address;
    logic [31:0] r_write_data;

    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    always_comb begin
        w_err = 1'b0;
        if (op_size == 2'b11)
            w_err = 1'b1;
        if (op_size == 2'b01 && addr[0])
            w_err = 1'b1;
        if (op_size == 2'b10 && addr[1:0] != 2'b00)
            w_err = 1'b1;
        if (ADDR_CHECK && addr >= 32'(MEM_BYTES))
            w_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (w_err)
                        w_next = S_DONE;
                    else if (op_store && op_size == 2'b10)
                        w_next = S_WR;
                    else
                        w_next = S_RD;
                end
            end
            S_RD:    w_next = r_store ? S_WR : S_DONE;
            S_WR:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0: w_byte = read_data[31:24];
            2'd1: w_byte = read_data[23:16];
            2'd2: w_byte = read_data[15:8];
            2'd3: w_byte = read_data[7:0];
            default: w_byte = 8'h00;
        endcase
        w_half = r_off[1] ? read_data[15:0] : read_data[31:16];

        w_load = read_data;
        case (r_size)
            2'b00: w_load = r_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01: w_load = r_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = read_data;
        endcase

        w_merged = read_data;
        if (r_size == 2'b00) begin
            case (r_off)
                2'd0: w_merged[31:24] = r_wdata[7:0];
                2'd1: w_merged[23:16] = r_wdata[7:0];
                2'd2: w_merged[15:8]  = r_wdata[7:0];
                2'd3: w_merged[7:0]   = r_wdata[7:0];
                default: w_merged = read_data;
            endcase
        end else if (r_off[1]) begin
            w_merged[15:0] = r_wdata;
        end else begin
            w_merged[31:16] = r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_store       <= 1'b0;
            r_size        <= 2'b00;
            r_unsigned    <= 1'b0;
            r_off         <= 2'b00;
            r_wdata       <= '0;
            r_err         <= 1'b0;
            r_rdata       <= '0;
            r_mem_address <= '0;
            r_write_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_store    <= op_store;
                        r_size     <= op_size;
                        r_unsigned <= op_unsigned;
                        r_off      <= addr[1:0];
                        r_wdata    <= wdata[15:0];
                        r_err      <= w_err;
                        if (!w_err) begin
                            r_mem_address <= {addr[31:2], 2'b00};
                            // SW skips RD, so its word is staged here.
                            if (op_store && op_size == 2'b10)
                                r_write_data <= wdata;
                        end
                    end
                end
                S_RD: begin
                    if (r_store)
                        r_write_data <= w_merged;
                    else
                        r_rdata <= w_load;
                end
                default: ;
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign addr_err      = (r_state == S_DONE) && r_err;
    assign sig_mem_read  = (r_state == S_RD);
    assign sig_mem_write = (r_state == S_WR);
    assign rdata         = r_rdata;
    assign mem_address   = r_mem_address;
    assign write_data    = r_write_data;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// tb_mips_load_store_unit
//   Directed bench for mips_load_store_unit with a 256-word memory model.
module tb_mips_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        op_store = 1'b0;
    logic [1:0]  op_size = 2'b00;
    logic        op_unsigned = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, addr_err, sig_mem_read, sig_mem_write;
    logic [31:0] rdata, mem_address, write_data, read_data;

    logic [31:0] mem [0:255];
    logic        tb_wr_en = 1'b0;
    logic [7:0]  tb_wr_idx = '0;
    logic [31:0] tb_wr_val = '0;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;

    // operation observations
    int          o_cyc, o_nrd, o_nwr;
    logic        o_err;
    logic [31:0] o_wd, o_ma;

    always #5 clk = ~clk;

    mips_load_store_unit #(.MEM_BYTES(1024), .ADDR_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_store(op_store),
        .op_size(op_size), .op_unsigned(op_unsigned), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .addr_err(addr_err),
        .rdata(rdata), .mem_address(mem_address), .write_data(write_data),
        .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write),
        .read_data(read_data)
    );

    assign read_data = mem[mem_address[9:2]];

    always @(posedge clk) begin
        if (tb_wr_en)
            mem[tb_wr_idx] <= tb_wr_val;
        else if (sig_mem_write)
            mem[mem_address[9:2]] <= write_data;
        if (done)
            n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd);
        bit got;
        @(negedge clk);
        op_store = st; op_size = sz; op_unsigned = un; addr = a; wdata = wd; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        o_cyc = 0; o_nrd = 0; o_nwr = 0; o_err = 1'b0; o_wd = 'x; o_ma = 'x;
        got = 1'b0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (sig_mem_read) begin o_nrd++; o_ma = mem_address; end
            if (sig_mem_write) begin o_nwr++; o_wd = write_data; end
            if (done) begin got = 1'b1; o_cyc = i; o_err = addr_err; end
        end
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] exp);
        run_op(1'b0, sz, un, a, 32'h0);
        check({tag, "_rdata"}, rdata, exp);
        check({tag, "_lat"}, 32'(o_cyc), 32'd2);
        check({tag, "_nrd"}, 32'(o_nrd), 32'd1);
        check({tag, "_nwr"}, 32'(o_nwr), 32'd0);
        check({tag, "_err"}, {31'b0, o_err}, 32'd0);
    endtask

    task automatic do_bad(input string tag, input logic st, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] prev);
        run_op(st, sz, 1'b0, a, 32'hDEADBEEF);
        check({tag, "_lat"}, 32'(o_cyc), 32'd1);
        check({tag, "_err"}, {31'b0, o_err}, 32'd1);
        check({tag, "_nrd"}, 32'(o_nrd), 32'd0);
        check({tag, "_nwr"}, 32'(o_nwr), 32'd0);
        check({tag, "_rdata"}, rdata, prev);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        // preload word 0x10 during reset
        tb_wr_en = 1'b1; tb_wr_idx = 8'd4; tb_wr_val = 32'h8899AABB;
        repeat (3) @(posedge clk);
        #1 tb_wr_en = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, addr_err}, 32'd0);
        check("rst_rd", {31'b0, sig_mem_read}, 32'd0);
        check("rst_wr", {31'b0, sig_mem_write}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_maddr", mem_address, 32'h0);
        check("rst_wdata", write_data, 32'h0);
        rst_n = 1'b1;

        do_load("lb11", 2'b00, 1'b0, 32'h11, 32'hFFFFFF99);
        check("lb11_maddr", o_ma, 32'h10);
        do_load("lbu11", 2'b00, 1'b1, 32'h11, 32'h00000099);
        do_load("lh12", 2'b01, 1'b0, 32'h12, 32'hFFFFAABB);
        do_load("lhu10", 2'b01, 1'b1, 32'h10, 32'h00008899);
        do_load("lw10", 2'b10, 1'b0, 32'h10, 32'h8899AABB);
        do_load("lb13", 2'b00, 1'b0, 32'h13, 32'hFFFFFFBB);

        run_op(1'b1, 2'b00, 1'b0, 32'h13, 32'h123456CC);
        check("sb13_lat", 32'(o_cyc), 32'd3);
        check("sb13_nrd", 32'(o_nrd), 32'd1);
        check("sb13_nwr", 32'(o_nwr), 32'd1);
        check("sb13_wd", o_wd, 32'h8899AACC);
        check("sb13_rdata", rdata, 32'hFFFFFFBB);
        do_load("lw_sb", 2'b10, 1'b0, 32'h10, 32'h8899AACC);

        run_op(1'b1, 2'b01, 1'b0, 32'h10, 32'h00001234);
        check("sh10_lat", 32'(o_cyc), 32'd3);
        check("sh10_wd", o_wd, 32'h1234AACC);
        do_load("lw_sh", 2'b10, 1'b0, 32'h10, 32'h1234AACC);

        run_op(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
        check("sw20_lat", 32'(o_cyc), 32'd2);
        check("sw20_nrd", 32'(o_nrd), 32'd0);
        check("sw20_nwr", 32'(o_nwr), 32'd1);
        check("sw20_wd", o_wd, 32'hCAFEF00D);
        check("sw20_rdata", rdata, 32'h1234AACC);
        check("sw20_mem", mem[8], 32'hCAFEF00D);

        do_bad("lw06", 1'b0, 2'b10, 32'h06, 32'h1234AACC);
        do_bad("lh11", 1'b0, 2'b01, 32'h11, 32'h1234AACC);
        do_bad("sz11", 1'b0, 2'b11, 32'h10, 32'h1234AACC);
        do_bad("lw400", 1'b0, 2'b10, 32'h400, 32'h1234AACC);
        do_bad("sh11", 1'b1, 2'b01, 32'h11, 32'h1234AACC);
        check("bad_mem", mem[4], 32'h1234AACC);

        // reset during RD of SB 0x13
        @(negedge clk);
        op_store = 1'b1; op_size = 2'b00; addr = 32'h13; wdata = 32'h000000EE; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        d0 = n_done;
        @(negedge clk);
        check("rr_in_rd", {31'b0, sig_mem_read}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rr_busy", {31'b0, busy}, 32'd0);
        check("rr_done", {31'b0, done}, 32'd0);
        check("rr_wr", {31'b0, sig_mem_write}, 32'd0);
        check("rr_rd", {31'b0, sig_mem_read}, 32'd0);
        check("rr_rdata", rdata, 32'h0);
        check("rr_maddr", mem_address, 32'h0);
        check("rr_wdata", write_data, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rr_nodone", 32'(n_done - d0), 32'd0);
        check("rr_mem", mem[4], 32'h1234AACC);

        // req held high: second access only starts from IDLE
        @(negedge clk);
        op_store = 1'b0; op_size = 2'b10; op_unsigned = 1'b0; addr = 32'h20; req = 1'b1;
        @(negedge clk);
        check("hold_c1_rd", {31'b0, sig_mem_read}, 32'd1);
        @(negedge clk);
        check("hold_c2_done", {31'b0, done}, 32'd1);
        check("hold_c2_rdata", rdata, 32'hCAFEF00D);
        @(negedge clk);
        check("hold_c3_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("hold_c4_rd", {31'b0, sig_mem_read}, 32'd1);
        req = 1'b0;
        @(negedge clk);
        check("hold_c5_done", {31'b0, done}, 32'd1);
        @(negedge clk);
        check("hold_c6_busy", {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
